// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI read channel between instruction fetch (grant 0) and the
// load unit (grant 1). One 8-beat 64-bit WRAP burst is in flight at a time.
// Round-robin priority flips to the other requester after each completed burst.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,

  input  logic                  ld_req_valid,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  output logic                  ld_req_ready,
  output logic                  ld_resp_valid,

  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [2:0]            resp_beat,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  busy,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_next;
  logic                  grant_q;
  logic                  prio_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            beat_q;

  logic                  any_req;
  logic                  pick_ld;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  r_done;

  // The ID and the low response bit carry no information for this block.
  logic                  unused_bits;
  assign unused_bits = ^{m_axi_rid, m_axi_rresp[0]};

  assign any_req = if_req_valid | ld_req_valid;
  // Load wins when it is alone, or when both ask and load holds priority.
  assign pick_ld = ld_req_valid & (~if_req_valid | prio_q);
  assign ar_fire = (state == ADDR) & m_axi_arready;
  assign r_fire  = (state == DATA) & m_axi_rvalid;
  assign r_done  = r_fire & m_axi_rlast;

  // Fixed burst shape: 8 beats of 8 bytes, wrapping on the cache line.
  assign m_axi_arlen   = 8'd7;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'd2;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'h6;
  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, grant_q};
  assign m_axi_araddr  = addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: grant in IDLE, address handshake, then beats until rlast.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    if (m_axi_arready) state_next = DATA;
      DATA:    if (r_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, line address, round-robin priority and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      beat_q  <= 3'd0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_q <= pick_ld;
        addr_q  <= pick_ld ? {ld_req_addr[ADDR_WIDTH-1:3], 3'b000}
                           : {if_req_addr[ADDR_WIDTH-1:3], 3'b000};
      end
      if (r_done) begin
        prio_q <= ~grant_q;
        beat_q <= 3'd0;
      end else if (r_fire) begin
        beat_q <= beat_q + 3'd1;
      end
    end
  end

  // Handshake and response steering toward the granted requester only.
  always_comb begin
    m_axi_arvalid = (state == ADDR);
    m_axi_rready  = (state == DATA);
    busy          = (state != IDLE);
    if_req_ready  = ar_fire & ~grant_q;
    ld_req_ready  = ar_fire &  grant_q;
    if_resp_valid = r_fire  & ~grant_q;
    ld_resp_valid = r_fire  &  grant_q;
    resp_data     = m_axi_rdata;
    resp_beat     = beat_q;
    resp_last     = m_axi_rlast;
    resp_err      = m_axi_rresp[1];
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
// Table of single-cycle vectors for one ifetch burst, hand sequences for
// arbitration, early rlast and reset, then random traffic against a model.
module tb_axi_read_arbiter;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           if_req_valid, ld_req_valid;
  logic [AW-1:0]  if_req_addr, ld_req_addr;
  logic           if_req_ready, ld_req_ready, if_resp_valid, ld_resp_valid;
  logic [DW-1:0]  resp_data;
  logic [2:0]     resp_beat;
  logic           resp_last, resp_err, busy;
  logic [IDW-1:0] m_axi_arid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arlock;
  logic [3:0]     m_axi_arcache;
  logic [2:0]     m_axi_arprot;
  logic           m_axi_arvalid, m_axi_arready;
  logic [IDW-1:0] m_axi_rid;
  logic [DW-1:0]  m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int errors = 0;

  axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
    .ld_req_ready(ld_req_ready), .ld_resp_valid(ld_resp_valid),
    .resp_data(resp_data), .resp_beat(resp_beat), .resp_last(resp_last),
    .resp_err(resp_err), .busy(busy),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        if_v;
    logic [63:0] if_a;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        e_arvalid;
    logic [63:0] e_araddr;
    logic        e_if_ready;
    logic        e_if_rv;
    logic [2:0]  e_beat;
    logic        e_err;
    logic        e_last;
    logic        e_busy;
    logic        e_rready;
  } vec_t;

  vec_t tbl[17];
  int   pat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1};

  function automatic vec_t mk(input logic iv, input logic [63:0] ia, input logic ar,
                              input logic rv, input logic rl, input logic [1:0] rr,
                              input logic [63:0] rd, input logic e_arv, input logic [63:0] e_addr,
                              input logic e_ifr, input logic e_ifrv, input logic [2:0] e_beat,
                              input logic e_busy, input logic e_rready);
    vec_t v;
    v.if_v = iv;  v.if_a = ia;  v.arready = ar;
    v.rvalid = rv; v.rlast = rl; v.rresp = rr; v.rdata = rd;
    v.e_arvalid = e_arv; v.e_araddr = e_addr; v.e_if_ready = e_ifr;
    v.e_if_rv = e_ifrv; v.e_beat = e_beat; v.e_err = rr[1]; v.e_last = rl;
    v.e_busy = e_busy; v.e_rready = e_rready;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = 0; ld_req_valid = 0; ld_req_addr = 0;
    m_axi_arready = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
  endtask

  task automatic doReset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req_valid  = v.if_v;
    if_req_addr   = v.if_a;
    ld_req_valid  = 0;
    ld_req_addr   = 0;
    m_axi_arready = v.arready;
    m_axi_rvalid  = v.rvalid;
    m_axi_rlast   = v.rlast;
    m_axi_rresp   = v.rresp;
    m_axi_rdata   = v.rdata;
    m_axi_rid     = IDW'($urandom);
  endtask

  task automatic checkRow(input vec_t v, input int i);
    checkOutput($sformatf("row%0d arvalid", i), m_axi_arvalid, v.e_arvalid);
    checkOutput($sformatf("row%0d araddr", i), m_axi_araddr, v.e_araddr);
    checkOutput($sformatf("row%0d arid", i), m_axi_arid, 0);
    checkOutput($sformatf("row%0d if_req_ready", i), if_req_ready, v.e_if_ready);
    checkOutput($sformatf("row%0d ld_req_ready", i), ld_req_ready, 0);
    checkOutput($sformatf("row%0d if_resp_valid", i), if_resp_valid, v.e_if_rv);
    checkOutput($sformatf("row%0d ld_resp_valid", i), ld_resp_valid, 0);
    checkOutput($sformatf("row%0d resp_beat", i), resp_beat, v.e_beat);
    checkOutput($sformatf("row%0d resp_err", i), resp_err, v.e_err);
    checkOutput($sformatf("row%0d busy", i), busy, v.e_busy);
    checkOutput($sformatf("row%0d rready", i), m_axi_rready, v.e_rready);
    if (v.e_if_rv) begin
      checkOutput($sformatf("row%0d resp_data", i), resp_data, v.rdata);
      checkOutput($sformatf("row%0d resp_last", i), resp_last, v.e_last);
    end
  endtask

  // Called in a cycle where the DUT should present AR; completes the handshake
  // and delivers beats 0..last_beat back to back.
  task automatic do_burst(input logic id, input logic [63:0] addr, input int last_beat,
                          input bit give_last);
    logic [63:0] d;
    m_axi_arready = 1;
    #1;
    checkOutput("burst arvalid", m_axi_arvalid, 1);
    checkOutput("burst araddr", m_axi_araddr, addr);
    checkOutput("burst arid", m_axi_arid, 64'(id));
    checkOutput("burst arlen", m_axi_arlen, 7);
    checkOutput("burst if_req_ready", if_req_ready, 64'(!id));
    checkOutput("burst ld_req_ready", ld_req_ready, 64'(id));
    tick();
    m_axi_arready = 0;
    if (id) ld_req_valid = 0;
    else    if_req_valid = 0;
    for (int b = 0; b <= last_beat; b++) begin
      d = {$urandom, $urandom};
      m_axi_rvalid = 1;
      m_axi_rdata  = d;
      m_axi_rlast  = give_last && (b == last_beat);
      #1;
      checkOutput("burst if_resp_valid", if_resp_valid, 64'(!id));
      checkOutput("burst ld_resp_valid", ld_resp_valid, 64'(id));
      checkOutput("burst resp_beat", resp_beat, 64'(b));
      checkOutput("burst resp_data", resp_data, d);
      checkOutput("burst rready", m_axi_rready, 1);
      tick();
    end
    m_axi_rvalid = 0;
    m_axi_rlast  = 0;
    m_axi_rdata  = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int cnt;
    bit if_pend, ld_pend;
    logic [63:0] if_addr, ld_addr;
    bit m_busy, m_hs, m_grant, m_prio;
    logic [63:0] m_addr;
    int m_beats;
    logic e_arv, e_rr, e_ifr, e_ldr, e_ifrv, e_ldrv;

    // ---- vector table: single ifetch with AR wait, R gaps and one error beat
    tbl[0] = mk(1, 64'h1003, 0, 0, 0, 2'b00, 0, 0, 64'h0,    0, 0, 3'd0, 0, 0);
    tbl[1] = mk(1, 64'h1003, 0, 0, 0, 2'b00, 0, 1, 64'h1000, 0, 0, 3'd0, 1, 0);
    tbl[2] = mk(1, 64'h1003, 0, 0, 0, 2'b00, 0, 1, 64'h1000, 0, 0, 3'd0, 1, 0);
    tbl[3] = mk(1, 64'h1003, 1, 0, 0, 2'b00, 0, 1, 64'h1000, 1, 0, 3'd0, 1, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (pat[k] != 0) begin
        tbl[4+k] = mk(0, 0, 0, 1, cnt == 7, (cnt == 3) ? 2'b10 : 2'b00, 64'(cnt),
                      0, 64'h1000, 0, 1, 3'(cnt), 1, 1);
        cnt++;
      end else begin
        tbl[4+k] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 64'h1000, 0, 0, 3'(cnt), 1, 1);
      end
    end
    tbl[16] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 64'h1000, 0, 0, 3'd0, 0, 0);

    doReset();
    #1;
    checkOutput("reset arvalid", m_axi_arvalid, 0);
    checkOutput("reset rready", m_axi_rready, 0);
    checkOutput("reset araddr", m_axi_araddr, 0);
    checkOutput("reset arid", m_axi_arid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset resp_beat", resp_beat, 0);
    checkOutput("reset if_req_ready", if_req_ready, 0);
    checkOutput("reset ld_resp_valid", ld_resp_valid, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkRow(tbl[i], i);
      tick();
    end

    // ---- simultaneous requests after reset, then round robin
    $display("[TB] arbitration sequence");
    doReset();
    if_req_valid = 1; if_req_addr = 64'h2000;
    ld_req_valid = 1; ld_req_addr = 64'h8000;
    #1;
    checkOutput("arb idle arvalid", m_axi_arvalid, 0);
    tick();
    do_burst(0, 64'h2000, 7, 1);
    if_req_valid = 1; if_req_addr = 64'h3000;
    #1;
    checkOutput("turnaround arvalid", m_axi_arvalid, 0);
    checkOutput("turnaround busy", busy, 0);
    tick();
    do_burst(1, 64'h8000, 7, 1);
    ld_req_valid = 1; ld_req_addr = 64'h9000;
    tick();
    do_burst(0, 64'h3000, 7, 1);

    // ---- early rlast: load alone, ends on beat 4
    $display("[TB] early rlast sequence");
    tick();
    do_burst(1, 64'h9000, 4, 1);
    if_req_valid = 1; if_req_addr = 64'h400D;
    #1;
    checkOutput("early busy", busy, 0);
    checkOutput("early resp_beat", resp_beat, 0);
    checkOutput("early rready", m_axi_rready, 0);
    tick();
    do_burst(0, 64'h4008, 7, 1);

    // ---- reset in the middle of a load burst
    $display("[TB] reset mid-burst sequence");
    ld_req_valid = 1; ld_req_addr = 64'hA000;
    tick();
    do_burst(1, 64'hA000, 4, 0);
    reset = 1;
    m_axi_rvalid = 1;
    tick();
    reset = 0;
    m_axi_rvalid = 1;
    m_axi_rdata = 64'h1234;
    #1;
    checkOutput("rst rready", m_axi_rready, 0);
    checkOutput("rst arvalid", m_axi_arvalid, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst if_resp_valid", if_resp_valid, 0);
    checkOutput("rst ld_resp_valid", ld_resp_valid, 0);
    m_axi_rvalid = 0;
    if_req_valid = 1; if_req_addr = 64'h5000;
    ld_req_valid = 1; ld_req_addr = 64'hB000;
    tick();
    do_burst(0, 64'h5000, 7, 1);
    tick();
    do_burst(1, 64'hB000, 7, 1);

    // ---- random traffic against a transaction-level model
    $display("[TB] random traffic");
    doReset();
    if_pend = 0; ld_pend = 0; if_addr = 0; ld_addr = 0;
    m_busy = 0; m_hs = 0; m_grant = 0; m_prio = 0; m_addr = 0; m_beats = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!if_pend && !(m_busy && !m_grant) && $urandom_range(0, 3) == 0) begin
        if_pend = 1; if_addr = {$urandom, $urandom};
      end
      if (!ld_pend && !(m_busy && m_grant) && $urandom_range(0, 3) == 0) begin
        ld_pend = 1; ld_addr = {$urandom, $urandom};
      end
      if_req_valid  = if_pend; if_req_addr = if_addr;
      ld_req_valid  = ld_pend; ld_req_addr = ld_addr;
      m_axi_arready = $urandom_range(0, 1) == 1;
      m_axi_rvalid  = $urandom_range(0, 2) != 0;
      m_axi_rlast   = m_axi_rvalid && (m_beats == 7 || $urandom_range(0, 15) == 0);
      m_axi_rresp   = 2'($urandom);
      m_axi_rdata   = {$urandom, $urandom};
      m_axi_rid     = IDW'($urandom);
      #1;
      e_arv  = m_busy && !m_hs;
      e_rr   = m_busy && m_hs;
      e_ifr  = e_arv && m_axi_arready && !m_grant;
      e_ldr  = e_arv && m_axi_arready && m_grant;
      e_ifrv = e_rr && m_axi_rvalid && !m_grant;
      e_ldrv = e_rr && m_axi_rvalid && m_grant;
      checkOutput("rnd arvalid", m_axi_arvalid, e_arv);
      checkOutput("rnd rready", m_axi_rready, e_rr);
      checkOutput("rnd busy", busy, m_busy);
      checkOutput("rnd if_req_ready", if_req_ready, e_ifr);
      checkOutput("rnd ld_req_ready", ld_req_ready, e_ldr);
      checkOutput("rnd if_resp_valid", if_resp_valid, e_ifrv);
      checkOutput("rnd ld_resp_valid", ld_resp_valid, e_ldrv);
      if (e_arv) begin
        checkOutput("rnd araddr", m_axi_araddr, m_addr);
        checkOutput("rnd arid", m_axi_arid, 64'(m_grant));
      end
      if (e_ifrv || e_ldrv) begin
        checkOutput("rnd resp_beat", resp_beat, 64'(m_beats));
        checkOutput("rnd resp_data", resp_data, m_axi_rdata);
        checkOutput("rnd resp_err", resp_err, m_axi_rresp[1]);
        checkOutput("rnd resp_last", resp_last, m_axi_rlast);
      end
      if (e_ifr) if_pend = 0;
      if (e_ldr) ld_pend = 0;
      if (!m_busy) begin
        if (if_req_valid || ld_req_valid) begin
          m_grant = (if_req_valid && ld_req_valid) ? m_prio : ld_req_valid;
          m_addr  = (m_grant ? ld_req_addr : if_req_addr) & 64'hFFFF_FFFF_FFFF_FFF8;
          m_busy  = 1; m_hs = 0; m_beats = 0;
        end
      end else if (!m_hs) begin
        if (m_axi_arready) m_hs = 1;
      end else if (m_axi_rvalid) begin
        if (m_axi_rlast) begin
          m_busy = 0; m_prio = !m_grant; m_beats = 0;
        end else begin
          m_beats++;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
